zx_int_controller: RTL
======================

Name: zx_int_controller

Overview:
- Generates the maskable interrupt request for the Z80 CPU core and supplies the data byte read during the interrupt-acknowledge cycle.
- Sits directly upstream of the CPU core. Drives its int_n input, and its vector byte is muxed into the CPU data-in path.
- Triggered once per video frame by the video timing block. Holds INT low for a fixed number of CPU T-states, or until the CPU acknowledges.

Parameters:
- INT_LEN, 32, INT pulse length in CPU T-states (clk_enable cycles). Legal range 1..255.
- VECTOR, 8'hFF, byte presented on the data bus during interrupt acknowledge.

Ports:
- clk  input  1  system clock; the CPU core runs on the same clock.
- rst  input  1  reset.
- clk_enable  input  1  CPU T-state enable; the same signal fed to the CPU core.
- enable  input  1  interrupt generation enable.
- frame_start  input  1  single-clk pulse from video timing marking the frame interrupt point.
- m1_n  input  1  CPU M1, active low.
- iorq_n  input  1  CPU IORQ, active low.
- int_n  output  1  interrupt request to CPU, active low, registered.
- vector_oe  output  1  high when vector must be muxed onto CPU data-in.
- vector  output  8  constant VECTOR.
- irq_acked  output  1  one-clk pulse when an acknowledge is accepted.
- irq_missed  output  1  one-clk pulse when a pulse expires without acknowledge.
- ack_count  output  8  count of accepted acknowledges, wraps 255->0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, int_n=1, vector_oe=0, irq_acked=0, irq_missed=0, ack_count=0.
- Acknowledge decode: intack = !m1_n && !iorq_n, evaluated combinationally each clk.
- Counter: cnt is 8 bits, decremented only on clks where clk_enable=1 and state=ACTIVE.
- State IDLE:
  - frame_start=1 and enable=1 -> ACTIVE, cnt<=INT_LEN.
  - int_n goes low on the next clk edge, so the registered output is low one clk after the frame_start pulse.
- State ACTIVE, int_n=0:
  - intack=1 -> ACKED. int_n<=1, irq_acked pulses for 1 clk, ack_count<=ack_count+1.
  - Otherwise, clk_enable=1 and cnt==1 -> IDLE. int_n<=1, irq_missed pulses for 1 clk.
  - Otherwise, clk_enable=1 -> cnt<=cnt-1.
  - frame_start=1 (and no intack) -> cnt<=INT_LEN (re-trigger); int_n stays 0.
  - Priority: intack > expiry > re-trigger > decrement.
- State ACKED:
  - Held while intack=1.
  - intack=0 -> IDLE.
  - frame_start is ignored in this state; no missed pulse.
- vector_oe is combinational: intack && (state==ACTIVE || state==ACKED).
  - Asserts in the same clk the CPU starts the acknowledge cycle.
  - Drops in the same clk intack ends.
  - intack in IDLE (spurious) never asserts vector_oe and never counts.
- enable=0 forces IDLE on the next clk from any state. int_n<=1, no irq_missed pulse, cnt unchanged (don't-care).
- clk_enable=0 freezes the counter but not the ack/trigger logic. Acknowledge is detected on every clk.
- Latency: the INT low period is exactly INT_LEN clk_enable edges after the frame_start clk, unless acknowledged or re-triggered.
- rst mid-pulse: int_n high on the next clk, state IDLE, counters cleared, no irq_missed/irq_acked pulse.

Test Plan:
- INT_LEN=32, clk_enable=1 every clk, enable=1, frame_start pulse, no ack -> int_n low for exactly 32 clks starting 1 clk after frame_start; irq_missed pulses once on the last edge; ack_count=0.
- clk_enable high 1 clk in 4, INT_LEN=32 -> int_n low for 128 clks (±alignment of the first enable); cnt frozen between enables.
- Ack 10 T-states after INT: m1_n=0 and iorq_n=0 for 3 clks -> vector_oe=1 for those 3 clks; vector=8'hFF; int_n=1 from the next clk; irq_acked one pulse; ack_count=1; no irq_missed.
- Spurious m1_n=0 and iorq_n=0 while IDLE -> vector_oe=0, ack_count unchanged. frame_start during ACKED -> ignored, int_n stays 1.
- Re-trigger: second frame_start 20 T-states into a 32-T pulse -> int_n low 52 T-states total, one irq_missed only.
- rst asserted mid-pulse at T=5, and separately enable=0 mid-pulse -> int_n=1 next clk, no irq_missed. 256 acks -> ack_count wraps to 0.

Source files
------------

// File: rtl/zx_int_controller.sv
// Frame interrupt generator for the Z80 core: drives INT low per frame
// and supplies the IM2/IM1 vector byte during interrupt acknowledge.
module zx_int_controller #(
  parameter int unsigned INT_LEN = 32,
  parameter logic [7:0]  VECTOR  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_enable,
  input  logic       enable,
  input  logic       frame_start,
  input  logic       m1_n,
  input  logic       iorq_n,
  output logic       int_n,
  output logic       vector_oe,
  output logic [7:0] vector,
  output logic       irq_acked,
  output logic       irq_missed,
  output logic [7:0] ack_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ACKED
  } state_t;

  localparam logic [7:0] LEN = 8'(INT_LEN);

  state_t     state;
  logic [7:0] cnt;
  logic       intack;
  logic       expire;

  assign intack = !m1_n && !iorq_n;
  assign expire = clk_enable && (cnt == 8'd1);
  assign vector = VECTOR;

  // Vector must reach the data-in mux in the same clk the CPU reads it.
  assign vector_oe = intack &&
    ((state == ACTIVE) || (state == ACKED));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      int_n      <= 1'b1;
      irq_acked  <= 1'b0;
      irq_missed <= 1'b0;
      ack_count  <= 8'd0;
    end else begin
      irq_acked  <= 1'b0;
      irq_missed <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        int_n <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (frame_start) begin
              state <= ACTIVE;
              cnt   <= LEN;
              int_n <= 1'b0;
            end
          end
          ACTIVE: begin
            if (intack) begin
              state     <= ACKED;
              int_n     <= 1'b1;
              irq_acked <= 1'b1;
              ack_count <= ack_count + 8'd1;
            end else if (expire) begin
              state      <= IDLE;
              int_n      <= 1'b1;
              irq_missed <= 1'b1;
            end else if (frame_start) begin
              cnt <= LEN;
            end else if (clk_enable) begin
              cnt <= cnt - 8'd1;
            end
          end
          ACKED: begin
            if (!intack) state <= IDLE;
          end
          default: begin
            state <= IDLE;
            int_n <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
